ifmap_row_feeder: RTL

//  Upstream stage of the CNN PE's IFmap input buffer. Accepts a raw pixel stream (valid/ready),

---
 rtl/ifmap_row_feeder_if.sv | 31 +++
 rtl/ifmap_row_feeder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ifmap_row_feeder_if.sv
// Pixel-stream and IFmap-buffer write signals of the row feeder.
// The slave modport is the feeder itself; the master modport is its environment.
interface ifmap_row_feeder_if #(
    parameter int DATA_WIDTH = 6,
    parameter int WORD_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [WORD_WIDTH-1:0] buf_din;
    logic                  buf_wen;
    logic                  buf_full;

    modport master (
        output s_data,
        output s_valid,
        output buf_full,
        input  s_ready,
        input  buf_din,
        input  buf_wen
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  buf_full,
        output s_ready,
        output buf_din,
        output buf_wen
    );
endinterface

// File: rtl/ifmap_row_feeder.sv
// Tags a raw pixel stream with start/end-of-row bits and writes it into the IFmap buffer
// through a single output register that absorbs buffer back-pressure.
module ifmap_row_feeder #(
    parameter int DATA_WIDTH = 6,
    parameter int WORD_WIDTH = 8,
    parameter int LEN_WIDTH  = 5,
    parameter int ROWS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LEN_WIDTH-1:0]  row_len,
    input  logic [ROWS_WIDTH-1:0] row_count,
    ifmap_row_feeder_if.slave     io,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_error
);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN
    } state_t;

    state_t                state;
    state_t                next_state;
    logic                  out_valid;
    logic [WORD_WIDTH-1:0] out_word;
    logic [WORD_WIDTH-1:0] new_word;
    logic [LEN_WIDTH-1:0]  col;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [ROWS_WIDTH-1:0] row;
    logic [ROWS_WIDTH-1:0] rows_q;
    logic                  accept;
    logic                  col_last;
    logic                  row_last;
    logic                  last_pixel;
    logic                  cfg_ok;
    logic                  job_start;

    assign io.buf_wen = out_valid & ~io.buf_full;
    assign io.buf_din = out_word;
    // The register may take a new pixel whenever it is empty or is being emptied this cycle.
    assign io.s_ready = (state == FEED) & (~out_valid | ~io.buf_full);
    assign busy       = (state != IDLE);

    assign accept     = io.s_valid & io.s_ready;
    assign col_last   = (col == (len_q - LEN_WIDTH'(1)));
    assign row_last   = (row == (rows_q - ROWS_WIDTH'(1)));
    assign last_pixel = accept & col_last & row_last;
    assign cfg_ok     = (row_len != '0) && (row_count != '0);
    assign job_start  = (state == IDLE) & start & cfg_ok;

    always_comb begin
        new_word                   = '0;
        new_word[DATA_WIDTH-1:0]   = io.s_data;
        new_word[WORD_WIDTH-1]     = (col == '0);
        new_word[WORD_WIDTH-2]     = col_last;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (job_start)  next_state = FEED;
                FEED:    if (last_pixel) next_state = DRAIN;
                DRAIN:   if (io.buf_wen) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Abort discards the pending word and counters and suppresses both status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            col       <= '0;
            row       <= '0;
            len_q     <= '0;
            rows_q    <= '0;
            done      <= 1'b0;
            cfg_error <= 1'b0;
        end else if (abort) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            col       <= '0;
            row       <= '0;
            done      <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            done      <= (state == DRAIN) & io.buf_wen;
            cfg_error <= (state == IDLE) & start & ~cfg_ok;
            if (job_start) begin
                len_q  <= row_len;
                rows_q <= row_count;
                col    <= '0;
                row    <= '0;
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_word  <= new_word;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + ROWS_WIDTH'(1);
                end else begin
                    col <= col + LEN_WIDTH'(1);
                end
            end else if (io.buf_wen) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
